// File: rtl/vdisk_pkg.sv
// vdisk_pkg: shared FSM state encoding and result codes for the virtual disk DMA
package vdisk_pkg;
  typedef enum logic [3:0] {IDLE, CHECK, SECT, SD_RD, SD_WAIT, XFER, MEM_WAIT, SD_WR, NEXT, FIN} state_t;
  localparam logic [7:0] ERR_OK = 8'd0;
  localparam logic [7:0] ERR_RANGE = 8'd5;
  localparam logic [7:0] ERR_NOTRDY = 8'd6;
  localparam logic [7:0] ERR_WPROT = 8'd7;
  localparam logic [7:0] ERR_PARAM = 8'd10;
endpackage

// File: rtl/vdisk_sectbuf.sv
// vdisk_sectbuf: sector buffer, SD byte port and DMA word port, registered reads
module vdisk_sectbuf #(
  parameter int SECT_WORDS = 256,
  parameter int WA = 8
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [8:0]    b_addr,
  input  logic          b_we,
  input  logic [7:0]    b_din,
  output logic [7:0]    b_dout,
  input  logic [WA-1:0] w_addr,
  input  logic          w_we,
  input  logic [15:0]   w_din,
  output logic [15:0]   w_dout
);
  logic [7:0] lo [SECT_WORDS];
  logic [7:0] hi [SECT_WORDS];
  logic [WA-1:0] ba;
  assign ba = b_addr[WA:1];
  // the word port wins a collision; the DMA never drives both at once
  always_ff @(posedge clk_sys) begin
    if (w_we) begin
      lo[w_addr] <= w_din[7:0];
      hi[w_addr] <= w_din[15:8];
    end else if (b_we) begin
      if (b_addr[0]) hi[ba] <= b_din;
      else lo[ba] <= b_din;
    end
  end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      w_dout <= '0;
      b_dout <= '0;
    end else begin
      w_dout <= {hi[w_addr], lo[w_addr]};
      b_dout <= b_addr[0] ? hi[ba] : lo[ba];
    end
  end
endmodule

// File: rtl/vdisk_dma.sv
// vdisk_dma: moves data between memory and virtual SD drives one sector at a time
module vdisk_dma
  import vdisk_pkg::*;
#(
  parameter int NDRV = 4,
  parameter int SECT_WORDS = 256,
  parameter int ADDR_W = 25,
  localparam int DW = NDRV > 1 ? $clog2(NDRV) : 1,
  localparam int WA = SECT_WORDS > 1 ? $clog2(SECT_WORDS) : 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              req,
  input  logic              req_write,
  input  logic [DW-1:0]     req_drive,
  input  logic [31:0]       req_lba,
  input  logic [15:0]       req_len,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [32*NDRV-1:0] drv_base,
  input  logic [32*NDRV-1:0] drv_end,
  input  logic [NDRV-1:0]   drv_ready,
  input  logic [NDRV-1:0]   drv_wprot,
  output logic              busy,
  output logic              done,
  output logic [7:0]        err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_we,
  output logic [15:0]       mem_dout,
  input  logic [15:0]       mem_din,
  input  logic              mem_ack,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  input  logic [8:0]        sd_buff_addr,
  input  logic [7:0]        sd_buff_dout,
  output logic [7:0]        sd_buff_din,
  input  logic              sd_buff_wr
);
  localparam logic [WA:0] SWN = SECT_WORDS[WA:0];
  state_t state, nxt;
  logic wr;
  logic [DW-1:0] drv, sel;
  logic [31:0] lba, base, lim;
  logic [15:0] rem;
  logic [WA:0] cnt, widx;
  logic drv_ok, zfill;
  logic [16:0] nsec;
  logic [33:0] sum;
  logic [7:0] ck_err;
  assign drv_ok = 32'(drv) < NDRV;
  assign sel = drv_ok ? drv : '0;
  assign base = drv_base[32*sel +: 32];
  assign lim = drv_end[32*sel +: 32];
  assign nsec = ({1'b0, rem} + 17'(SECT_WORDS - 1)) >> WA;
  // 34-bit sum so a wrap past 2^32 is caught as a range error
  assign sum = {2'b0, base} + {2'b0, lba} + {17'b0, nsec};
  assign ck_err = (!drv_ok || !drv_ready[sel]) ? ERR_NOTRDY :
                  (wr && drv_wprot[sel]) ? ERR_WPROT :
                  (rem == '0 || mem_addr[0]) ? ERR_PARAM :
                  (sum[33:32] != 2'b0 || sum[31:0] > lim) ? ERR_RANGE : ERR_OK;
  assign zfill = wr && widx >= cnt && widx != SWN;
  assign busy = state != IDLE;
  assign done = state == FIN;
  assign err = err_r;
  assign mem_rd = state == MEM_WAIT && wr;
  assign mem_we = state == MEM_WAIT && !wr;
  assign sd_rd = state == SD_RD;
  assign sd_wr = state == SD_WR;
  logic [7:0] err_r;
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = req ? CHECK : IDLE;
      CHECK: nxt = ck_err != ERR_OK ? FIN : SECT;
      SECT: nxt = wr ? XFER : SD_RD;
      SD_RD, SD_WR: nxt = sd_ack ? SD_WAIT : state;
      SD_WAIT: nxt = sd_ack ? SD_WAIT : wr ? NEXT : XFER;
      XFER: nxt = (!wr || widx < cnt) ? MEM_WAIT : widx == SWN ? SD_WR : XFER;
      MEM_WAIT: nxt = !mem_ack ? MEM_WAIT : (!wr && widx + 1'b1 == cnt) ? NEXT : XFER;
      NEXT: nxt = rem == '0 ? FIN : SECT;
      FIN: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr <= 1'b0;
      drv <= '0;
      lba <= '0;
      rem <= '0;
      mem_addr <= '0;
      sd_lba <= '0;
      cnt <= '0;
      widx <= '0;
      err_r <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          wr <= req_write;
          drv <= req_drive;
          lba <= req_lba;
          rem <= req_len;
          mem_addr <= req_addr;
        end
        CHECK: begin
          err_r <= ck_err;
          sd_lba <= base + lba;
        end
        SECT: begin
          cnt <= rem >= 16'(SECT_WORDS) ? SWN : rem[WA:0];
          widx <= '0;
        end
        XFER: if (zfill) widx <= widx + 1'b1;
        MEM_WAIT: if (mem_ack) begin
          widx <= widx + 1'b1;
          mem_addr <= mem_addr + ADDR_W'(2);
          rem <= rem - 16'd1;
        end
        NEXT: sd_lba <= sd_lba + 32'd1;
        default: ;
      endcase
    end
  end
  vdisk_sectbuf #(.SECT_WORDS(SECT_WORDS), .WA(WA)) u_buf (
    .clk_sys(clk_sys),
    .reset(reset),
    .b_addr(sd_buff_addr),
    .b_we(sd_buff_wr && sd_ack && state != IDLE),
    .b_din(sd_buff_dout),
    .b_dout(sd_buff_din),
    .w_addr(widx[WA-1:0]),
    .w_we((state == XFER && zfill) || (state == MEM_WAIT && wr && mem_ack)),
    .w_din(state == MEM_WAIT ? mem_din : 16'd0),
    .w_dout(mem_dout)
  );
endmodule

// File: tb/tb_vdisk_dma.sv
// tb_vdisk_dma: directed table of transfers against behavioural memory and SD models
module tb_vdisk_dma;
  logic clk_sys = 0;
  logic reset = 0;
  logic req = 0, req_write = 0;
  logic [1:0] req_drive = 0;
  logic [31:0] req_lba = 0;
  logic [15:0] req_len = 0;
  logic [24:0] req_addr = 0;
  logic [127:0] drv_base, drv_end;
  logic [3:0] drv_ready, drv_wprot;
  logic busy, done, mem_rd, mem_we, sd_rd, sd_wr;
  logic [7:0] err, sd_buff_din;
  logic [24:0] mem_addr;
  logic [15:0] mem_dout, mem_din;
  logic mem_ack, sd_ack, sd_buff_wr;
  logic [31:0] sd_lba;
  logic [8:0] sd_buff_addr;
  logic [7:0] sd_buff_dout;

  vdisk_dma dut (
    .clk_sys(clk_sys), .reset(reset), .req(req), .req_write(req_write), .req_drive(req_drive),
    .req_lba(req_lba), .req_len(req_len), .req_addr(req_addr), .drv_base(drv_base), .drv_end(drv_end),
    .drv_ready(drv_ready), .drv_wprot(drv_wprot), .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_ack(mem_ack), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din),
    .sd_buff_wr(sd_buff_wr)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        wr;
    logic [1:0]  drv;
    logic [31:0] lba;
    logic [15:0] len;
    logic [24:0] addr;
    logic [7:0]  err;
    int          nsd;
    logic [31:0] slba;
    int          dly;
  } vec_t;

  vec_t vt[15];
  int checks = 0, failures = 0;
  int nsd_tot = 0, nmem_tot = 0, done_tot = 0, hold_viol = 0, sd_viol = 0, cur_dly = 0;
  logic [31:0] sd_log [64];
  logic sd_type [64];
  logic [7:0] cap [2048];
  logic [15:0] mem [8192];

  function automatic logic [7:0] pat(input logic [31:0] l, input int b);
    logic [31:0] t;
    t = l * 32'd13 + 32'(b) * 32'd5 + 32'(b / 256) * 32'd77;
    return t[7:0];
  endfunction

  function automatic logic [15:0] memval(input int k);
    logic [31:0] t;
    t = 32'(k) * 32'h0123 + 32'h1357;
    return t[15:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {58'd0, busy, done, mem_rd, mem_we, sd_rd, sd_wr}, 0);
    chk({nm, "_maddr"}, 64'(mem_addr), 0);
    chk({nm, "_sdlba"}, 64'(sd_lba), 0);
    chk({nm, "_err"}, 64'(err), 0);
    chk({nm, "_mdout"}, 64'(mem_dout), 0);
    chk({nm, "_bdin"}, 64'(sd_buff_din), 0);
  endtask

  always @(negedge clk_sys) if (done) done_tot++;

  // memory: fixed read pattern, holds handshake checks, optional ack delay
  initial begin
    logic [24:0] a;
    logic r;
    mem_ack = 0;
    mem_din = 0;
    forever begin
      @(negedge clk_sys);
      if (!reset && (mem_rd || mem_we)) begin
        a = mem_addr;
        r = mem_rd;
        for (int k = 0; k < cur_dly; k++) begin
          @(negedge clk_sys);
          if (mem_rd !== r || mem_we !== ~r || mem_addr !== a) hold_viol++;
        end
        if (r) mem_din = memval(int'(a[13:1]));
        else mem[a[13:1]] = mem_dout;
        nmem_tot++;
        mem_ack = 1;
        @(negedge clk_sys);
        mem_ack = 0;
        if (mem_rd || mem_we) hold_viol++;
      end
    end
  end

  // SD card: fills the buffer with a per-sector pattern or captures it
  initial begin
    int idx;
    sd_ack = 0;
    sd_buff_addr = 0;
    sd_buff_dout = 0;
    sd_buff_wr = 0;
    forever begin
      @(negedge clk_sys);
      if (!reset && (sd_rd || sd_wr)) begin
        idx = nsd_tot % 64;
        sd_log[idx] = sd_lba;
        sd_type[idx] = sd_wr;
        if (sd_rd && sd_wr) sd_viol++;
        nsd_tot++;
        sd_ack = 1;
        @(negedge clk_sys);
        if (sd_rd || sd_wr) sd_viol++;
        for (int j = 0; j < 512; j++) begin
          sd_buff_addr = 9'(j);
          if (sd_type[idx]) begin
            @(negedge clk_sys);
            cap[(idx % 4) * 512 + j] = sd_buff_din;
          end else begin
            sd_buff_dout = pat(sd_log[idx], j);
            sd_buff_wr = 1;
            @(negedge clk_sys);
          end
        end
        sd_buff_wr = 0;
        sd_ack = 0;
      end
    end
  end

  task automatic run_vec(input vec_t v, input string nm);
    int s0, m0, cyc, wi, k;
    s0 = nsd_tot;
    m0 = nmem_tot;
    cur_dly = v.dly;
    @(negedge clk_sys);
    req = 1; req_write = v.wr; req_drive = v.drv; req_lba = v.lba; req_len = v.len; req_addr = v.addr;
    @(negedge clk_sys);
    req = 0; req_write = ~v.wr; req_drive = v.drv ^ 2'd1; req_lba = 32'hDEAD_BEEF; req_len = 16'h7777; req_addr = 25'h1;
    chk({nm, "_busy"}, 64'(busy), 1);
    cyc = 1;
    while (!done && cyc < 30000) begin
      @(negedge clk_sys);
      cyc++;
    end
    chk({nm, "_done"}, 64'(done), 1);
    chk({nm, "_err"}, 64'(err), 64'(v.err));
    if (v.err != 0) chk({nm, "_lat"}, 64'(cyc <= 4), 1);
    chk({nm, "_nsd"}, 64'(nsd_tot - s0), 64'(v.nsd));
    chk({nm, "_nmem"}, 64'(nmem_tot - m0), v.err == 0 ? 64'(v.len) : 64'd0);
    if (v.nsd > 0) begin
      chk({nm, "_lba"}, 64'(sd_log[s0 % 64]), 64'(v.slba));
      chk({nm, "_type"}, 64'(sd_type[s0 % 64]), 64'(v.wr));
    end
    if (v.nsd > 1) chk({nm, "_lba2"}, 64'(sd_log[(s0 + 1) % 64]), 64'(v.slba + 32'd1));
    @(negedge clk_sys);
    chk({nm, "_pulse"}, {62'd0, done, busy}, 0);
    if (v.err == 0) begin
      for (int i = 0; i < int'(v.len); i++) begin
        wi = int'(v.addr[13:1]) + i;
        k = i / 256;
        if (v.wr)
          chk({nm, "_wdat"}, {48'd0, cap[((s0 + k) % 4) * 512 + 2 * (i % 256) + 1], cap[((s0 + k) % 4) * 512 + 2 * (i % 256)]}, 64'(memval(wi)));
        else
          chk({nm, "_rdat"}, 64'(mem[wi % 8192]), {48'd0, pat(v.slba + 32'(k), 2 * (i % 256) + 1), pat(v.slba + 32'(k), 2 * (i % 256))});
      end
      if (v.wr)
        for (int b = 2 * int'(v.len); b < v.nsd * 512; b++)
          chk({nm, "_zero"}, 64'(cap[((s0 + b / 512) % 4) * 512 + b % 512]), 0);
    end
  endtask

  initial begin
    int m0, d0, c;
    drv_base = {32'hFFFF_FFF0, 32'd0, 32'd1000, 32'd0};
    drv_end = {32'hFFFF_FFFF, 32'd0, 32'd2000, 32'd100};
    drv_ready = 4'b1011;
    drv_wprot = 4'b1000;
    #1 reset = 1;
    repeat (3) @(negedge clk_sys);
    chk_zero("rst");
    reset = 0;
    vt[0]  = '{1'b0, 2'd1, 32'd3, 16'd300, 25'h100, 8'd0, 2, 32'd1003, 0};
    vt[1]  = '{1'b1, 2'd1, 32'd7, 16'd10, 25'h800, 8'd0, 1, 32'd1007, 0};
    vt[2]  = '{1'b0, 2'd1, 32'd999, 16'd512, 25'h1000, 8'd5, 0, 32'd0, 0};
    vt[3]  = '{1'b0, 2'd1, 32'd998, 16'd512, 25'h2000, 8'd0, 2, 32'd1998, 0};
    vt[4]  = '{1'b0, 2'd1, 32'd0, 16'd4, 25'h101, 8'd10, 0, 32'd0, 0};
    vt[5]  = '{1'b0, 2'd2, 32'd0, 16'd4, 25'h100, 8'd6, 0, 32'd0, 0};
    vt[6]  = '{1'b1, 2'd3, 32'd0, 16'd4, 25'h100, 8'd7, 0, 32'd0, 0};
    vt[7]  = '{1'b1, 2'd2, 32'd0, 16'd0, 25'h101, 8'd6, 0, 32'd0, 0};
    vt[8]  = '{1'b1, 2'd3, 32'd0, 16'd0, 25'h100, 8'd7, 0, 32'd0, 0};
    vt[9]  = '{1'b0, 2'd1, 32'd0, 16'd0, 25'h100, 8'd10, 0, 32'd0, 0};
    vt[10] = '{1'b0, 2'd3, 32'd15, 16'd1, 25'h100, 8'd5, 0, 32'd0, 0};
    vt[11] = '{1'b0, 2'd3, 32'd14, 16'd1, 25'h2E00, 8'd0, 1, 32'hFFFF_FFFE, 0};
    vt[12] = '{1'b1, 2'd0, 32'd0, 16'd256, 25'h2800, 8'd0, 1, 32'd0, 0};
    vt[13] = '{1'b1, 2'd1, 32'd20, 16'd6, 25'h2A00, 8'd0, 1, 32'd1020, 5};
    vt[14] = '{1'b0, 2'd0, 32'd5, 16'd4, 25'h2C00, 8'd0, 1, 32'd5, 3};
    for (int i = 0; i < 15; i++) run_vec(vt[i], $sformatf("v%0d", i));
    cur_dly = 0;
    m0 = nmem_tot;
    d0 = done_tot;
    @(negedge clk_sys);
    req = 1; req_write = 0; req_drive = 1; req_lba = 40; req_len = 20; req_addr = 25'h3000;
    @(negedge clk_sys);
    req = 0;
    c = 0;
    while (nmem_tot < m0 + 5 && c < 5000) begin
      @(negedge clk_sys);
      #1;
      c++;
    end
    chk("abort_reach", 64'(nmem_tot >= m0 + 5), 1);
    @(negedge clk_sys);
    reset = 1;
    #1;
    chk_zero("abort");
    repeat (3) @(negedge clk_sys);
    reset = 0;
    repeat (3) @(negedge clk_sys);
    chk("abort_nodone", 64'(done_tot), 64'(d0));
    chk("abort_idle", 64'(busy), 0);
    run_vec('{1'b0, 2'd1, 32'd50, 16'd20, 25'h3000, 8'd0, 1, 32'd1050, 0}, "post");
    chk("mem_hold", 64'(hold_viol), 0);
    chk("sd_single", 64'(sd_viol), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
